// File: rtl/bsg_mcl_axil_pkg.sv
// Shared types and helpers for the manycore AXI-Lite mailbox datapath.
// Kept minimal so both the word buffer and the packer agree on word width.
package bsg_mcl_axil_pkg;

    localparam int mcl_axil_data_width_gp = 32;

    typedef logic [mcl_axil_data_width_gp-1:0] mcl_axil_word_t;

    // Number of AXI-Lite words that make up one packed manycore request.
    function automatic int mcl_ratio(input int fifo_w, input int axil_w);
        return (axil_w > 0) ? (fifo_w / axil_w) : 0;
    endfunction

endpackage

// File: rtl/bsg_mcl_word_buf_async.sv
// Circular word buffer with occupancy-based full/empty and a registered vacancy count.
// Depth need not be a power of two; pointers wrap explicitly at els_p-1.
module bsg_mcl_word_buf_async
    import bsg_mcl_axil_pkg::*;
#(
    parameter int width_p       = mcl_axil_data_width_gp,
    parameter int els_p         = 8,
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [cnt_width_lp-1:0] vacancy_o
);

    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] wr_ptr_r;
    logic [ptr_width_lp-1:0] rd_ptr_r;
    logic [cnt_width_lp-1:0] occ_r;
    logic [cnt_width_lp-1:0] vac_r;
    logic                    push;
    logic                    pop;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from registered occupancy, never from v_i.
    assign ready_o   = (occ_r != els_cnt_lp);
    assign v_o       = (occ_r != '0);
    assign push      = v_i & ready_o;
    assign pop       = yumi_i & v_o;
    assign data_o    = mem_r[rd_ptr_r];
    assign vacancy_o = vac_r;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            vac_r    <= els_cnt_lp;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10: begin
                    occ_r <= occ_r + 1'b1;
                    vac_r <= vac_r - 1'b1;
                end
                2'b01: begin
                    occ_r <= occ_r - 1'b1;
                    vac_r <= vac_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bsg_mcl_axil_fifos_tx.sv
// Host-to-manycore word packer: buffers AXI-Lite words and packs ratio_lp of them
// into one fifo_width_p request, word 0 in the least significant slot.
module bsg_mcl_axil_fifos_tx
    import bsg_mcl_axil_pkg::*;
#(
    parameter int fifo_width_p      = 128,
    parameter int req_credits_p     = 2,
    parameter int axil_data_width_p = mcl_axil_data_width_gp,
    localparam int ratio_lp         = mcl_ratio(fifo_width_p, axil_data_width_p),
    localparam int els_lp           = ratio_lp * req_credits_p,
    localparam int vac_width_lp     = $clog2(els_lp + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [axil_data_width_p-1:0] axil_req_i,
    input  logic                         axil_req_v_i,
    output logic                         axil_req_ready_o,
    output logic [fifo_width_p-1:0]      fifo_req_o,
    output logic                         fifo_req_v_o,
    input  logic                         fifo_req_ready_i,
    output logic [vac_width_lp-1:0]      req_vacancy_o
);

    localparam int cnt_width_lp = $clog2(ratio_lp + 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(ratio_lp);

    if ((ratio_lp * axil_data_width_p != fifo_width_p) || (ratio_lp < 2) || (req_credits_p < 1)) begin : g_param_check
        $fatal(1, "bsg_mcl_axil_fifos_tx: fifo_width_p must be ratio*axil_data_width_p (ratio>=2), req_credits_p>=1");
    end

    logic [axil_data_width_p-1:0] buf_data;
    logic                         buf_v;
    logic                         pop;
    logic                         send;
    logic [cnt_width_lp-1:0]      count_r;
    logic [cnt_width_lp-1:0]      count_n;
    logic                         fifo_v_r;
    logic [axil_data_width_p-1:0] slot_r [ratio_lp];

    bsg_mcl_word_buf_async #(
        .width_p (axil_data_width_p),
        .els_p   (els_lp)
    ) word_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (axil_req_i),
        .v_i       (axil_req_v_i),
        .ready_o   (axil_req_ready_o),
        .data_o    (buf_data),
        .v_o       (buf_v),
        .yumi_i    (pop),
        .vacancy_o (req_vacancy_o)
    );

    // A full packer never pops, so a handshake cycle is never also a pop cycle.
    assign send = fifo_v_r & fifo_req_ready_i;
    assign pop  = buf_v & (count_r < full_cnt_lp);

    always_comb begin
        count_n = count_r;
        if (send) begin
            count_n = '0;
        end else if (pop) begin
            count_n = count_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r  <= '0;
            fifo_v_r <= 1'b0;
            for (int i = 0; i < ratio_lp; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            count_r  <= count_n;
            fifo_v_r <= (count_n == full_cnt_lp);
            for (int i = 0; i < ratio_lp; i++) begin
                if (pop && (count_r == cnt_width_lp'(i))) begin
                    slot_r[i] <= buf_data;
                end
            end
        end
    end

    for (genvar g = 0; g < ratio_lp; g++) begin : g_pack
        assign fifo_req_o[g*axil_data_width_p +: axil_data_width_p] = slot_r[g];
    end

    assign fifo_req_v_o = fifo_v_r;

endmodule
